// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - sequential register-file dump engine with stream output
// Walks a window of a register file, one beat per two cycles, with abort and backpressure.
module reg_dump #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       base,
  input  logic [6:0]       count,
  input  logic             abort,
  output logic [5:0]       sel,
  input  logic [WIDTH-1:0] rd_data,
  output logic             lock,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [5:0]       out_index,
  output logic             out_last,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

  localparam logic [6:0] LP_DEPTH = 7'(DEPTH);
  localparam logic [5:0] LP_LAST  = 6'(DEPTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [5:0]       r_idx;
  logic [6:0]       r_rem;
  logic [WIDTH-1:0] r_out_data;
  logic [5:0]       r_out_index;
  logic             r_out_last;
  logic             r_aborted;

  logic [6:0]       w_base_ext;
  logic [5:0]       w_base_mod;
  logic [6:0]       w_rem_load;
  logic [5:0]       w_idx_next;
  logic             w_lock;
  logic             w_valid;
  logic             w_done;
  logic             w_aborted;

  assign w_base_ext = {1'b0, base};
  assign w_base_mod = 6'(w_base_ext % LP_DEPTH);
  assign w_rem_load = (count > LP_DEPTH) ? LP_DEPTH : count;
  // Wrap at the configured depth, not at the 6-bit index range
  assign w_idx_next = (r_idx == LP_LAST) ? 6'd0 : r_idx + 6'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (count == 7'd0) ? S_DONE : S_FETCH;
      S_FETCH: w_state_next = abort ? S_DONE : S_SEND;
      S_SEND: begin
        if (abort)          w_state_next = S_DONE;
        else if (out_ready) w_state_next = r_out_last ? S_DONE : S_FETCH;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_lock    = 1'b1;
    w_valid   = 1'b0;
    w_done    = 1'b0;
    w_aborted = 1'b0;
    case (r_state)
      S_IDLE:  w_lock = 1'b0;
      S_SEND:  w_valid = 1'b1;
      S_DONE: begin
        w_done    = 1'b1;
        w_aborted = r_aborted;
      end
      default: w_lock = 1'b1;
    endcase
  end

  // An abort wins over a same-cycle handshake, so the in-flight beat is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_aborted <= 1'b0;
            if (count != 7'd0) begin
              r_idx <= w_base_mod;
              r_rem <= w_rem_load;
            end
          end
        end
        S_FETCH: begin
          if (abort) begin
            r_aborted <= 1'b1;
          end else begin
            r_out_data  <= rd_data;
            r_out_index <= r_idx;
            r_out_last  <= (r_rem == 7'd1);
          end
        end
        S_SEND: begin
          if (abort) begin
            r_aborted <= 1'b1;
          end else if (out_ready) begin
            r_rem <= r_rem - 7'd1;
            r_idx <= w_idx_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel       = r_idx;
  assign lock      = w_lock;
  assign out_valid = w_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign done      = w_done;
  assign aborted   = w_aborted;

endmodule
